// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, default widths and saturation helper for the conv engine
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam int DEF_K      = 3;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_W_W    = 8;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_mac_acc.sv
// rtl/conv_mac_acc.sv - signed multiply-accumulate with bias load, ReLU and output saturation
module conv_mac_acc
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int W_W    = DEF_W_W,
    parameter int ACC_W  = 40,
    parameter int OUT_DW = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_i,
    input  logic signed [ACC_W-1:0]  bias_i,
    input  logic                     acc_en_i,
    input  logic signed [DATA_W-1:0] img_i,
    input  logic signed [W_W-1:0]    w_i,
    input  logic                     relu_i,
    input  logic                     cap_i,
    output logic signed [OUT_DW-1:0] res_o
);

    localparam int PW = DATA_W + W_W;

    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  relu_val;
    logic signed [OUT_DW-1:0] res_q;
    logic signed [OUT_DW-1:0] res_d;

    // The result is taken from the sum including the last product so it is ready in WRITE.
    always_comb begin
        prod     = PW'(img_i) * PW'(w_i);
        sum      = acc_q + ACC_W'(prod);
        relu_val = (relu_i && sum[ACC_W-1]) ? '0 : sum;
        res_d    = OUT_DW'(saturate(64'(relu_val), OUT_DW));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            if (load_i)
                acc_q <= bias_i;
            else if (acc_en_i)
                acc_q <= sum;
            if (cap_i)
                res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/conv_mc_engine.sv
// rtl/conv_mc_engine.sv - single-output-channel convolution engine: FSM, tap/pixel counters, address generation
module conv_mc_engine
    import conv_pkg::*;
#(
    parameter int K_H    = DEF_K,
    parameter int K_W    = DEF_K,
    parameter int IN_H   = 14,
    parameter int IN_W   = 13,
    parameter int IN_CH  = 4,
    parameter int OUT_CH = 10,
    parameter int STRIDE = 1,
    parameter int DATA_W = DEF_DATA_W,
    parameter int W_W    = DEF_W_W,
    parameter int OUT_DW = 24,
    localparam int OUT_H = (IN_H - K_H) / STRIDE + 1,
    localparam int OUT_W = (IN_W - K_W) / STRIDE + 1,
    localparam int ACC_W = DATA_W + W_W + $clog2(IN_CH * K_H * K_W) + 1,
    localparam int OC_W  = $clog2(OUT_CH),
    localparam int IA_W  = $clog2(IN_CH * IN_H * IN_W),
    localparam int WA_W  = $clog2(OUT_CH * IN_CH * K_H * K_W),
    localparam int OA_W  = $clog2(OUT_H * OUT_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [OC_W-1:0]          oc_sel,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic                     relu_en,
    output logic [IA_W-1:0]          img_addr,
    input  logic signed [DATA_W-1:0] img_rdata,
    output logic [WA_W-1:0]          w_addr,
    input  logic signed [W_W-1:0]    w_rdata,
    output logic                     out_we,
    output logic [OA_W-1:0]          out_addr,
    output logic signed [OUT_DW-1:0] out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = 16;

    state_e                  state_q;
    logic                    busy_q, done_q, out_we_q, vld_q, relu_q;
    logic [OC_W-1:0]         oc_q;
    logic signed [ACC_W-1:0] bias_q;
    logic [CW-1:0]           ch_q, kh_q, kw_q, r_q, c_q;
    logic [CW-1:0]           ch_d, kh_d, kw_d, r_d, c_d;
    logic                    last_tap, last_pix;
    logic [IA_W-1:0]         img_addr_q;
    logic [WA_W-1:0]         w_addr_q;
    logic [OA_W-1:0]         out_addr_q;

    function automatic logic [IA_W-1:0] ia_f(input logic [CW-1:0] ch, kh, kw, r, c);
        return IA_W'(int'(ch) * IN_H * IN_W + (int'(r) * STRIDE + int'(kh)) * IN_W
                     + int'(c) * STRIDE + int'(kw));
    endfunction

    function automatic logic [WA_W-1:0] wa_f(input logic [OC_W-1:0] oc, input logic [CW-1:0] ch, kh, kw);
        return WA_W'(((int'(oc) * IN_CH + int'(ch)) * K_H + int'(kh)) * K_W + int'(kw));
    endfunction

    // Tap order: kw innermost, then kh, then input channel.
    always_comb begin
        kw_d = kw_q + 1'b1;
        kh_d = kh_q;
        ch_d = ch_q;
        if (kw_q == CW'(K_W - 1)) begin
            kw_d = '0;
            kh_d = kh_q + 1'b1;
            if (kh_q == CW'(K_H - 1)) begin
                kh_d = '0;
                ch_d = ch_q + 1'b1;
            end
        end
        c_d = c_q + 1'b1;
        r_d = r_q;
        if (c_q == CW'(OUT_W - 1)) begin
            c_d = '0;
            r_d = r_q + 1'b1;
        end
        last_tap = (ch_q == CW'(IN_CH - 1)) && (kh_q == CW'(K_H - 1)) && (kw_q == CW'(K_W - 1));
        last_pix = (r_q == CW'(OUT_H - 1)) && (c_q == CW'(OUT_W - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_we_q   <= 1'b0;
            vld_q      <= 1'b0;
            relu_q     <= 1'b0;
            oc_q       <= '0;
            bias_q     <= '0;
            ch_q       <= '0;
            kh_q       <= '0;
            kw_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            img_addr_q <= '0;
            w_addr_q   <= '0;
            out_addr_q <= '0;
        end else begin
            done_q   <= 1'b0;
            out_we_q <= 1'b0;
            // Read data returns one cycle after each RUN address, so the product is valid next cycle.
            vld_q    <= (state_q == ST_RUN);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        oc_q       <= oc_sel;
                        bias_q     <= bias;
                        relu_q     <= relu_en;
                        ch_q       <= '0;
                        kh_q       <= '0;
                        kw_q       <= '0;
                        r_q        <= '0;
                        c_q        <= '0;
                        img_addr_q <= ia_f('0, '0, '0, '0, '0);
                        w_addr_q   <= wa_f(oc_sel, '0, '0, '0);
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_tap) begin
                        state_q <= ST_FLUSH;
                    end else begin
                        ch_q       <= ch_d;
                        kh_q       <= kh_d;
                        kw_q       <= kw_d;
                        img_addr_q <= ia_f(ch_d, kh_d, kw_d, r_q, c_q);
                        w_addr_q   <= wa_f(oc_q, ch_d, kh_d, kw_d);
                    end
                end
                ST_FLUSH: begin
                    out_we_q   <= 1'b1;
                    out_addr_q <= OA_W'(int'(r_q) * OUT_W + int'(c_q));
                    state_q    <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (last_pix) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        r_q        <= r_d;
                        c_q        <= c_d;
                        ch_q       <= '0;
                        kh_q       <= '0;
                        kw_q       <= '0;
                        img_addr_q <= ia_f('0, '0, '0, r_d, c_d);
                        w_addr_q   <= wa_f(oc_q, '0, '0, '0);
                        state_q    <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    conv_mac_acc #(
        .DATA_W (DATA_W),
        .W_W    (W_W),
        .ACC_W  (ACC_W),
        .OUT_DW (OUT_DW)
    ) u_mac (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   ((state_q == ST_IDLE && start) || state_q == ST_WRITE),
        .bias_i   ((state_q == ST_IDLE) ? bias : bias_q),
        .acc_en_i (vld_q),
        .img_i    (img_rdata),
        .w_i      (w_rdata),
        .relu_i   (relu_q),
        .cap_i    (state_q == ST_FLUSH),
        .res_o    (out_data)
    );

    assign img_addr = img_addr_q;
    assign w_addr   = w_addr_q;
    assign out_we   = out_we_q;
    assign out_addr = out_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_conv_mc_engine.sv
// tb/tb_conv_mc_engine.sv - directed self-checking bench for conv_mc_engine
module tb_conv_mc_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // Instance A: 5x5 input, 2 channels, 3x3 kernel, stride 1
    logic              start_a = 1'b0;
    logic [3:0]        oc_a = '0;
    logic signed [37:0] bias_a = '0;
    logic              relu_a = 1'b0;
    logic [5:0]        img_addr_a;
    logic signed [23:0] img_rdata_a;
    logic [7:0]        w_addr_a;
    logic signed [7:0] w_rdata_a;
    logic              out_we_a;
    logic [3:0]        out_addr_a;
    logic signed [23:0] out_data_a;
    logic              busy_a, done_a;

    // Instance B: 7x7 input, 1 channel, 3x3 kernel, stride 2
    logic              start_b = 1'b0;
    logic [3:0]        oc_b = '0;
    logic signed [36:0] bias_b = '0;
    logic              relu_b = 1'b0;
    logic [5:0]        img_addr_b;
    logic signed [23:0] img_rdata_b;
    logic [6:0]        w_addr_b;
    logic signed [7:0] w_rdata_b;
    logic              out_we_b;
    logic [3:0]        out_addr_b;
    logic signed [23:0] out_data_b;
    logic              busy_b, done_b;

    conv_mc_engine #(.K_H(3), .K_W(3), .IN_H(5), .IN_W(5), .IN_CH(2), .OUT_CH(10), .STRIDE(1),
                     .DATA_W(24), .W_W(8), .OUT_DW(24)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .oc_sel(oc_a), .bias(bias_a), .relu_en(relu_a),
        .img_addr(img_addr_a), .img_rdata(img_rdata_a), .w_addr(w_addr_a), .w_rdata(w_rdata_a),
        .out_we(out_we_a), .out_addr(out_addr_a), .out_data(out_data_a), .busy(busy_a), .done(done_a));

    conv_mc_engine #(.K_H(3), .K_W(3), .IN_H(7), .IN_W(7), .IN_CH(1), .OUT_CH(10), .STRIDE(2),
                     .DATA_W(24), .W_W(8), .OUT_DW(24)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .oc_sel(oc_b), .bias(bias_b), .relu_en(relu_b),
        .img_addr(img_addr_b), .img_rdata(img_rdata_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
        .out_we(out_we_b), .out_addr(out_addr_b), .out_data(out_data_b), .busy(busy_b), .done(done_b));

    logic signed [23:0] img_a [0:63];
    logic signed [7:0]  w_a   [0:255];
    logic signed [23:0] img_b [0:63];
    logic signed [7:0]  w_b   [0:127];

    always @(posedge clk) begin
        img_rdata_a <= img_a[img_addr_a];
        w_rdata_a   <= w_a[w_addr_a];
        img_rdata_b <= img_b[img_addr_b];
        w_rdata_b   <= w_b[w_addr_b];
    end

    int wcnt_a = 0;
    int wcnt_b = 0;
    logic [3:0]         wl_addr_a [0:255];
    logic signed [23:0] wl_data_a [0:255];
    logic [3:0]         wl_addr_b [0:63];
    logic signed [23:0] wl_data_b [0:63];

    always @(negedge clk) begin
        if (out_we_a === 1'b1) begin
            wl_addr_a[wcnt_a[7:0]] <= out_addr_a;
            wl_data_a[wcnt_a[7:0]] <= out_data_a;
            wcnt_a <= wcnt_a + 1;
        end
        if (out_we_b === 1'b1) begin
            wl_addr_b[wcnt_b[5:0]] <= out_addr_b;
            wl_data_b[wcnt_b[5:0]] <= out_data_b;
            wcnt_b <= wcnt_b + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_a(input int oc, input longint b, input bit relu, input bit repulse,
                         output int cyc, output int wbase, output int nwr, output int w0);
        w0 = wcnt_a;
        @(negedge clk);
        start_a = 1'b1; oc_a = 4'(oc); bias_a = 38'(b); relu_a = relu;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        wbase = int'(w_addr_a);
        while (done_a !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start_a = repulse && (cyc == 30);
        end
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        nwr = wcnt_a - w0;
    endtask

    task automatic check_pixels_a(input string tag, input int w0, input int nwr, input longint exp);
        for (int i = 0; i < 9 && i < nwr; i++) begin
            chk({tag, "_addr"}, wl_addr_a[w0 + i], i);
            chk({tag, "_data"}, wl_data_a[w0 + i], exp);
        end
    endtask

    int cyc, wbase, nwr, w0, a44;
    int exp9 [0:8];

    initial begin
        for (int i = 0; i < 64; i++) img_a[i] = 24'sd1;
        for (int i = 0; i < 256; i++) w_a[i] = 8'sd1;
        for (int i = 0; i < 64; i++) img_b[i] = 24'(i);
        for (int i = 0; i < 128; i++) w_b[i] = (i < 9) ? 8'sd1 : 8'sd0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_we", out_we_a, 0);
        chk("rst_img_addr", img_addr_a, 0);
        chk("rst_w_addr", w_addr_a, 0);
        chk("rst_out_addr", out_addr_a, 0);
        chk("rst_out_data", out_data_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // All ones: each output is 2*9 = 18, done 9*20 cycles after RUN entry
        run_a(0, 0, 0, 0, cyc, wbase, nwr, w0);
        chk("ones_done_cyc", cyc, 180);
        chk("ones_nwr", nwr, 9);
        chk("ones_wbase", wbase, 0);
        chk("ones_busy_after", busy_a, 0);
        check_pixels_a("ones", w0, nwr, 18);

        for (int i = 0; i < 18; i++) w_a[i] = -8'sd1;
        run_a(0, 0, 0, 0, cyc, wbase, nwr, w0);
        chk("neg_nwr", nwr, 9);
        check_pixels_a("neg", w0, nwr, -18);
        run_a(0, 0, 1, 0, cyc, wbase, nwr, w0);
        chk("neg_relu_nwr", nwr, 9);
        check_pixels_a("neg_relu", w0, nwr, 0);
        run_a(0, 20, 1, 0, cyc, wbase, nwr, w0);
        check_pixels_a("neg_bias20", w0, nwr, 2);

        for (int i = 0; i < 18; i++) w_a[i] = 8'sd127;
        for (int i = 0; i < 50; i++) img_a[i] = 24'sd8388607;
        run_a(0, 0, 0, 0, cyc, wbase, nwr, w0);
        chk("sat_hi_nwr", nwr, 9);
        check_pixels_a("sat_hi", w0, nwr, 8388607);
        for (int i = 0; i < 50; i++) img_a[i] = -24'sd8388608;
        run_a(0, 0, 0, 0, cyc, wbase, nwr, w0);
        check_pixels_a("sat_lo", w0, nwr, -8388608);

        for (int i = 0; i < 50; i++) img_a[i] = 24'sd1;
        for (int i = 0; i < 18; i++) w_a[i] = 8'sd1;
        run_a(0, 0, 0, 1, cyc, wbase, nwr, w0);
        chk("repulse_done_cyc", cyc, 180);
        chk("repulse_nwr", nwr, 9);
        check_pixels_a("repulse", w0, nwr, 18);

        // Abort mid-RUN of pixel 1 after pixel 0 has already written 18
        @(negedge clk);
        start_a = 1'b1; oc_a = 4'd0; bias_a = '0; relu_a = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        repeat (24) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_we", out_we_a, 0);
        chk("abort_img_addr", img_addr_a, 0);
        chk("abort_out_data", out_data_a, 0);
        w0 = wcnt_a;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_write", wcnt_a - w0, 0);
        chk("abort_idle", busy_a, 0);
        run_a(0, 0, 0, 0, cyc, wbase, nwr, w0);
        chk("after_abort_cyc", cyc, 180);
        chk("after_abort_nwr", nwr, 9);
        check_pixels_a("after_abort", w0, nwr, 18);

        // Channel 9 with a distinct weight set; every other channel holds 3
        for (int i = 0; i < 50; i++) img_a[i] = 24'(((i * 7) % 11) - 5);
        for (int i = 0; i < 256; i++) w_a[i] = 8'sd3;
        for (int j = 0; j < 18; j++) w_a[162 + j] = 8'((j % 5) - 2);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int s;
                s = -3;
                for (int ch = 0; ch < 2; ch++)
                    for (int kh = 0; kh < 3; kh++)
                        for (int kw = 0; kw < 3; kw++)
                            s += int'(img_a[ch * 25 + (r + kh) * 5 + c + kw])
                               * int'(w_a[((18 + ch) * 3 + kh) * 3 + kw]);
                exp9[r * 3 + c] = (s < 0) ? 0 : s;
            end
        end
        run_a(9, -3, 1, 0, cyc, wbase, nwr, w0);
        chk("oc9_wbase", wbase, 162);
        chk("oc9_nwr", nwr, 9);
        for (int i = 0; i < 9 && i < nwr; i++) begin
            chk("oc9_addr", wl_addr_a[w0 + i], i);
            chk("oc9_data", wl_data_a[w0 + i], exp9[i]);
        end

        // Stride 2 ramp: out(r,c) = 126r + 18c + 72, per-pixel cost 11 cycles
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        a44 = -1;
        while (done_b !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 44) a44 = int'(img_addr_b);
        end
        repeat (2) @(negedge clk);
        chk("s2_done_cyc", cyc, 99);
        chk("s2_tap0_px11", a44, 16);
        chk("s2_nwr", wcnt_b, 9);
        for (int i = 0; i < 9 && i < wcnt_b; i++) begin
            chk("s2_addr", wl_addr_b[i], i);
            chk("s2_data", wl_data_b[i], 126 * (i / 3) + 18 * (i % 3) + 72);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_mc_engine.md
CONV_MC_ENGINE -- requirements
Module: conv_mc_engine

Interface
REQ-001 SHALL have parameter K_H, default 3, kernel height.
REQ-002 SHALL have parameter K_W, default 3, kernel width.
REQ-003 SHALL have parameters IN_H, IN_W, defaults 14, 13, input plane size.
REQ-004 SHALL have parameter IN_CH, default 4, input channels summed per output pixel.
REQ-005 SHALL have parameter OUT_CH, default 10, number of selectable output-channel weight sets.
REQ-006 SHALL have parameter STRIDE, default 1; OUT_H=(IN_H-K_H)/STRIDE+1, OUT_W=(IN_W-K_W)/STRIDE+1 (localparams).
REQ-007 SHALL have parameters DATA_W 24 (image), W_W 8 (weight), OUT_DW 24 (result); ACC_W=DATA_W+W_W+$clog2(IN_CH*K_H*K_W)+1 (localparam).
REQ-008 clk  in  1  single clock, rising edge.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 start  in  1  one-cycle request to process one output channel.
REQ-011 oc_sel  in  $clog2(OUT_CH)  output channel, sampled with start.
REQ-012 bias  in  ACC_W signed  initial accumulator value, sampled with start.
REQ-013 relu_en  in  1  clamp negatives to 0 when 1, sampled with start.
REQ-014 img_addr / img_rdata  out / in  $clog2(IN_CH*IN_H*IN_W) / DATA_W signed  image read port, data valid exactly 1 cycle after address.
REQ-015 w_addr / w_rdata  out / in  $clog2(OUT_CH*IN_CH*K_H*K_W) / W_W signed  weight read port, same 1-cycle latency.
REQ-016 out_we, out_addr, out_data  out  1, $clog2(OUT_H*OUT_W), OUT_DW signed  result write port.
REQ-017 busy, done  out  1, 1  busy high IDLE-excluded; done one-cycle pulse.

Function
REQ-018 SHALL implement states IDLE, RUN, FLUSH, WRITE, DONE.
REQ-019 IDLE: start=1 latches oc_sel, bias, relu_en, clears pixel/tap counters, loads accumulator with bias, goes RUN; start outside IDLE SHALL be ignored.
REQ-020 RUN: one tap per cycle, order ch outer, kh, kw inner; img_addr=ch*IN_H*IN_W+(r*STRIDE+kh)*IN_W+(c*STRIDE+kw); w_addr=((oc*IN_CH+ch)*K_H+kh)*K_W+kw.
REQ-021 Returned product img_rdata*w_rdata (full-precision signed) SHALL be added to the accumulator in the following cycle; after N=IN_CH*K_H*K_W taps go FLUSH (accumulates last product).
REQ-022 WRITE: out_we=1 for exactly one cycle, out_addr=r*OUT_W+c, out_data=sat_OUT_DW(relu_en ? max(acc,0) : acc); accumulator reloaded with bias.
REQ-023 After WRITE: next pixel in raster order (c wraps to 0 at OUT_W, r increments) to RUN; after last pixel to DONE.
REQ-024 Per-pixel cost SHALL be exactly N+2 cycles; DONE lasts one cycle with done=1, then IDLE.
REQ-025 Saturation: values above 2^(OUT_DW-1)-1 or below -2^(OUT_DW-1) SHALL clamp to those limits; no wrap.
REQ-026 Accumulator SHALL never overflow for any input values (width ACC_W).
REQ-027 Outside WRITE out_we=0; address outputs SHALL hold last value when idle.

Reset
REQ-028 rst=1 SHALL force IDLE immediately; busy, done, out_we=0; counters, accumulator, addresses, out_data=0.
REQ-029 Reset during RUN/WRITE SHALL abort with no further writes; first start after release begins a fresh channel from pixel 0.

Structure
REQ-030 Shared package conv_pkg SHALL hold the state enum, default K/DATA_W/W_W values and a saturate function.
REQ-031 One sub-module conv_mac_acc (signed multiply, ACC_W accumulate, load-bias, ReLU, saturate) SHALL be instantiated; FSM and address generation stay in top.

Verification
REQ-032 IN 5x5, IN_CH=2, K=3, all images 1, weights 1, bias 0 -> 9 writes, addresses 0..8, each data 18; done 9*20 cycles after RUN entry.
REQ-033 Same, weights -1, relu_en=0 -> all outputs -18; relu_en=1 -> all 0; bias=20, relu_en=1 -> all 2.
REQ-034 Images 8388607, weights 127, OUT_DW 24 -> every output 8388607 (saturated); images -8388608 -> -8388608.
REQ-035 IN 7x7, STRIDE=2, K=3, ramp image -> OUT 3x3, 9 writes, img_addr of tap 0 of pixel (1,1) = 16, values match software model.
REQ-036 start re-pulsed during RUN -> ignored, write count unchanged; rst asserted mid-RUN -> outputs 0 same cycle, no write, next start completes normally.
REQ-037 oc_sel=9 -> w_addr base 9*IN_CH*K_H*K_W, results match channel-9 model.
